sync_fifo: RTL and testbench

- Single-clock, synchronous first-in-first-out byte buffer with registered read data, full/empty status and occupancy count.
- Sits between a producer and a consumer in the same clock domain.
- The producer pushes with `write` while `full` is low; the consumer pops with `read` while `empty` is low.
- Sticky overflow/underflow flags report handshake violations for debug.

---
 rtl/sync_fifo.sv | 79 +++++++
 tb/tb_sync_fifo.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered read data, occupancy count and
// sticky overflow/underflow debug flags.
module sync_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] LP_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_odata;
  logic                  r_ovf;
  logic                  r_unf;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_ok;
  logic                  w_wr_ok;

  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == LP_FULL);
    w_rd_ok = read & ~w_empty;
    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    w_wr_ok = write & (~w_full | w_rd_ok);
  end

  // Storage is deliberately not reset; reset only blocks a write in that cycle.
  always_ff @(posedge CLK) begin
    if (!RST && w_wr_ok) r_mem[r_wptr] <= iData;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_odata <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) begin
        r_rptr  <= r_rptr + 1'b1;
        r_odata <= r_mem[r_rptr];
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (write && !w_wr_ok) r_ovf <= 1'b1;
      if (read && w_empty)   r_unf <= 1'b1;
    end
  end

  assign oData     = r_odata;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a queue model of the FIFO feeds a
// scoreboard of expected read data, compared as the DUT produces it.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [DW-1:0] iData = '0;
  logic [DW-1:0] oData;
  logic          full;
  logic          empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .write(write), .read(read), .iData(iData),
    .oData(oData), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] m_odata;
  logic          m_ovf;
  logic          m_unf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_status();
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("odata_hold", 32'(oData), 32'(m_odata));
  endtask

  task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] d);
    logic rd_ok, wr_ok;
    logic [DW-1:0] e;
    write = wr; read = rd; iData = d;
    rd_ok = rd && (mq.size() != 0);
    wr_ok = wr && ((mq.size() != DEPTH) || rd_ok);
    if (rd && mq.size() == 0) m_unf = 1'b1;
    if (wr && !wr_ok) m_ovf = 1'b1;
    if (rd_ok) sb.push_back(mq.pop_front());
    if (wr_ok) mq.push_back(d);
    @(posedge CLK); #1;
    write = 1'b0; read = 1'b0;
    if (rd_ok) begin
      e = sb.pop_front();
      m_odata = e;
      chk("rdata", 32'(oData), 32'(e));
    end
    check_status();
  endtask

  task automatic do_reset(input logic wr, input logic [DW-1:0] d);
    RST = 1'b1; write = wr; read = 1'b0; iData = d;
    @(posedge CLK); #1;
    RST = 1'b0; write = 1'b0;
    mq.delete(); sb.delete();
    m_odata = '0; m_ovf = 1'b0; m_unf = 1'b0;
    check_status();
  endtask

  initial begin
    // reset with a concurrent write that must not be stored
    do_reset(1'b1, 8'h55);
    cycle(1'b0, 1'b0, 8'h00);

    // fill, then a dropped 9th write
    for (int i = 1; i <= 9; i++) cycle(1'b1, 1'b0, 8'(i));
    // drain, then a 9th read on empty
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 8'h00);

    // streaming: write and read every cycle
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'(i));
    cycle(1'b0, 1'b1, 8'h00);

    // interleaved push/pop so both pointers wrap
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 8'(8'h10 + i));
      if (i % 3 == 2) begin
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
      end
    end
    // fill to full, then simultaneous read+write
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'hA0 + i));
    cycle(1'b1, 1'b1, 8'hAA);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00);
    // read+write on empty: write accepted, read ignored
    cycle(1'b1, 1'b1, 8'h77);
    cycle(1'b0, 1'b1, 8'h00);

    // mid-operation reset
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
    do_reset(1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h3C);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
